// File: rtl/elevator_scan_ctrl.sv
// SCAN-scheduled elevator controller: latched request bitmap, timed travel and door,
// emergency-stop freeze/resume, saturating served-stop counter.
module elevator_scan_ctrl #(
  parameter int unsigned FLOORS      = 4,
  parameter int unsigned MOVE_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES = 3,
  parameter int unsigned CNT_W       = 8,
  localparam int unsigned FW         = $clog2(FLOORS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stop,
  input  logic              req_valid,
  input  logic [FW-1:0]     req_floor,
  output logic              req_ready,
  output logic [FW-1:0]     floor,
  output logic              dir_up,
  output logic              moving,
  output logic              door_open,
  output logic [FLOORS-1:0] pending,
  output logic [CNT_W-1:0]  served_count
);

  localparam int unsigned TMAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MOVE = 2'd1;
  localparam logic [1:0] DOOR = 2'd2;
  localparam logic [1:0] HALT = 2'd3;

  logic [1:0]        state, saved, eff;
  logic [TW-1:0]     timer;

  logic [1:0]        state_nxt, saved_nxt;
  logic [FW-1:0]     floor_nxt, next_floor, arrive;
  logic              dir_nxt;
  logic [TW-1:0]     timer_nxt;
  logic [FLOORS-1:0] pending_nxt;
  logic [CNT_W-1:0]  served_nxt;
  logic              above, below, accept, door_hit, enter_door;
  int unsigned       floor_u;

  assign req_ready = rst && (state != HALT);
  assign moving    = (state == MOVE);
  assign door_open = (state == DOOR) || (state == HALT && saved == DOOR);

  always_comb begin
    // Leaving HALT runs the saved state's step on that same edge, so a stop of N edges delays by exactly N.
    eff     = (state == HALT) ? saved : state;
    floor_u = 32'(floor);
    above   = 1'b0;
    below   = 1'b0;
    for (int unsigned i = 0; i < FLOORS; i++) begin
      if (pending[i]) begin
        if (i > floor_u) above = 1'b1;
        if (i < floor_u) below = 1'b1;
      end
    end
    accept   = req_valid && req_ready && (32'(req_floor) < FLOORS);
    door_hit = accept && (state == DOOR) && (req_floor == floor);

    state_nxt   = state;
    saved_nxt   = saved;
    floor_nxt   = floor;
    dir_nxt     = dir_up;
    timer_nxt   = timer;
    served_nxt  = served_count;
    pending_nxt = pending;
    enter_door  = 1'b0;
    arrive      = floor;
    next_floor  = dir_up ? floor + 1'b1 : floor - 1'b1;
    if (accept && !door_hit) pending_nxt[req_floor] = 1'b1;

    if (stop) begin
      state_nxt = HALT;
      if (state != HALT) saved_nxt = state;
    end else begin
      case (eff)
        IDLE: begin
          state_nxt = IDLE;
          timer_nxt = '0;
          if (pending[floor]) begin
            state_nxt  = DOOR;
            enter_door = 1'b1;
          end else if (above && (dir_up || !below)) begin
            dir_nxt   = 1'b1;
            state_nxt = MOVE;
          end else if (below) begin
            dir_nxt   = 1'b0;
            state_nxt = MOVE;
          end
        end
        MOVE: begin
          state_nxt = MOVE;
          if (timer == TW'(MOVE_CYCLES - 1)) begin
            timer_nxt = '0;
            floor_nxt = next_floor;
            arrive    = next_floor;
            if (pending[next_floor]) begin
              state_nxt  = DOOR;
              enter_door = 1'b1;
            end else if (dir_up ? (next_floor == FW'(FLOORS - 1)) : (next_floor == '0)) begin
              state_nxt = IDLE;
            end
          end else begin
            timer_nxt = timer + 1'b1;
          end
        end
        DOOR: begin
          state_nxt = DOOR;
          if (door_hit) begin
            timer_nxt = '0;
          end else if (timer == TW'(DOOR_CYCLES - 1)) begin
            timer_nxt = '0;
            state_nxt = IDLE;
          end else begin
            timer_nxt = timer + 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    if (enter_door) begin
      pending_nxt[arrive] = 1'b0;
      if (served_count != '1) served_nxt = served_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      saved        <= IDLE;
      floor        <= '0;
      dir_up       <= 1'b1;
      timer        <= '0;
      pending      <= '0;
      served_count <= '0;
    end else begin
      state        <= state_nxt;
      saved        <= saved_nxt;
      floor        <= floor_nxt;
      dir_up       <= dir_nxt;
      timer        <= timer_nxt;
      pending      <= pending_nxt;
      served_count <= served_nxt;
    end
  end

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Scoreboard bench for elevator_scan_ctrl: expected door stops are queued by the stimulus
// and checked by a monitor when door_open rises/falls; plus directed point checks.
module tb_elevator_scan_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       stop = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_floor = '0;
  logic       req_ready, dir_up, moving, door_open;
  logic [1:0] floor;
  logic [3:0] pending;
  logic [7:0] served_count;

  logic       req3_valid = 1'b0;
  logic [1:0] req3_floor = '0;
  logic       ready3, dir3, mov3, door3;
  logic [1:0] floor3;
  logic [2:0] pend3;
  logic [7:0] served3;

  elevator_scan_ctrl #(.FLOORS(4), .MOVE_CYCLES(4), .DOOR_CYCLES(3), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .stop(stop), .req_valid(req_valid), .req_floor(req_floor),
    .req_ready(req_ready), .floor(floor), .dir_up(dir_up), .moving(moving),
    .door_open(door_open), .pending(pending), .served_count(served_count));

  elevator_scan_ctrl #(.FLOORS(3), .MOVE_CYCLES(4), .DOOR_CYCLES(3), .CNT_W(8)) u_dut3 (
    .clk(clk), .rst(rst), .stop(1'b0), .req_valid(req3_valid), .req_floor(req3_floor),
    .req_ready(ready3), .floor(floor3), .dir_up(dir3), .moving(mov3),
    .door_open(door3), .pending(pend3), .served_count(served3));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int at_edge;
    int fl;
    int served;
    int pend;
    int len;
  } exp_t;
  exp_t sb[$];

  // Monitor: a door opening is the DUT's "output transaction".
  initial begin
    logic prev;
    int   rise;
    exp_t e;
    prev = 1'b0;
    rise = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev = 1'b0;
      end else begin
        if (door_open && !prev) begin
          rise = cyc;
          if (sb.size() == 0) begin
            check("door_unexpected", 32'd1, 32'd0);
          end else begin
            e = sb[0];
            check("door_edge", cyc, e.at_edge);
            check("door_floor", 32'(floor), e.fl);
            check("door_served", 32'(served_count), e.served);
            check("door_pending", 32'(pending), e.pend);
          end
        end
        if (!door_open && prev && sb.size() > 0) begin
          e = sb.pop_front();
          check("door_len", cyc - rise, e.len);
        end
        prev = door_open;
      end
    end
  end

  task automatic at(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic send(input int f, output int e);
    req_valid = 1'b1;
    req_floor = 2'(f);
    e = cyc + 1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int e, f;
    repeat (2) @(negedge clk);
    check("rst_floor", 32'(floor), 0);
    check("rst_dir", 32'(dir_up), 1);
    check("rst_pending", 32'(pending), 0);
    check("rst_served", 32'(served_count), 0);
    check("rst_moving", 32'(moving), 0);
    check("rst_door", 32'(door_open), 0);
    check("rst_ready", 32'(req_ready), 0);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(req_ready), 1);

    // 1: request floor 2 from floor 0
    sb.push_back('{cyc + 1 + 9, 2, 1, 0, 3});
    send(2, e);
    at(e + 1);  check("t1_moving", 32'(moving), 1);
    check("t1_floor0", 32'(floor), 0);
    at(e + 5);  check("t1_floor1", 32'(floor), 1);
    at(e + 8);  check("t1_floor1_hold", 32'(floor), 1);
    at(e + 12); check("t1_door_closed", 32'(door_open), 0);
    check("t1_idle", 32'(moving), 0);
    check("t1_pending", 32'(pending), 0);

    // 2: requests 3 and 1, then 0 reverses the sweep
    do_reset();
    sb.push_back('{cyc + 1 + 5, 1, 1, 8, 3});
    sb.push_back('{cyc + 1 + 17, 3, 2, 0, 3});
    send(3, e);
    send(1, f);
    at(e + 1);  check("t2_dir_up", 32'(dir_up), 1);
    check("t2_moving", 32'(moving), 1);
    at(e + 13); check("t2_pass_floor2", 32'(floor), 2);
    check("t2_pass_moving", 32'(moving), 1);
    at(e + 20); check("t2_door_closed", 32'(door_open), 0);
    sb.push_back('{cyc + 1 + 13, 0, 3, 0, 3});
    send(0, f);
    at(f + 1);  check("t2_dir_down", 32'(dir_up), 0);
    check("t2_moving_down", 32'(moving), 1);
    at(f + 16); check("t2_floor0", 32'(floor), 0);
    check("t2_idle", 32'(door_open), 0);

    // 3: emergency stop for 5 edges mid-segment 1->2
    do_reset();
    sb.push_back('{cyc + 1 + 18, 3, 1, 0, 3});
    send(3, e);
    at(e + 6);  stop = 1'b1;
    at(e + 9);  check("t3_halt_moving", 32'(moving), 0);
    check("t3_halt_ready", 32'(req_ready), 0);
    check("t3_halt_floor", 32'(floor), 1);
    check("t3_halt_door", 32'(door_open), 0);
    send(0, f);
    at(e + 11); stop = 1'b0;
    at(e + 13); check("t3_floor1_late", 32'(floor), 1);
    at(e + 14); check("t3_floor2_late", 32'(floor), 2);
    at(e + 21); check("t3_pending_clear", 32'(pending), 0);
    check("t3_closed", 32'(door_open), 0);

    // 4: re-request current floor while door open restarts the door timer
    do_reset();
    sb.push_back('{cyc + 1 + 5, 1, 1, 0, 5});
    send(1, e);
    at(e + 6);  send(1, f);
    at(e + 8);  check("t4_door_held", 32'(door_open), 1);
    check("t4_served", 32'(served_count), 1);
    check("t4_pending", 32'(pending), 0);
    at(e + 9);  check("t4_door_held2", 32'(door_open), 1);
    at(e + 10); check("t4_door_closed", 32'(door_open), 0);

    // 6: async reset mid-MOVE at floor 2 (from floor 1, served 1)
    send(3, e);
    at(e + 7);  check("t6_pre_floor", 32'(floor), 2);
    check("t6_pre_pending", 32'(pending), 8);
    check("t6_pre_served", 32'(served_count), 1);
    check("t6_pre_moving", 32'(moving), 1);
    #2 rst = 1'b0;
    #1;
    check("t6_floor", 32'(floor), 0);
    check("t6_pending", 32'(pending), 0);
    check("t6_served", 32'(served_count), 0);
    check("t6_moving", 32'(moving), 0);
    check("t6_ready", 32'(req_ready), 0);
    check("t6_dir", 32'(dir_up), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 5: FLOORS=3 build, out-of-range request and duplicate
    req3_valid = 1'b1;
    req3_floor = 2'd3;
    e = cyc + 1;
    @(negedge clk);
    req3_floor = 2'd2;
    @(negedge clk);
    @(negedge clk);
    req3_valid = 1'b0;
    check("t5_pending", 32'(pend3), 4);
    check("t5_moving", 32'(mov3), 1);
    at(e + 10); check("t5_floor", 32'(floor3), 2);
    check("t5_door", 32'(door3), 1);
    check("t5_served", 32'(served3), 1);
    check("t5_pending_clear", 32'(pend3), 0);
    at(e + 20); check("t5_one_stop", 32'(served3), 1);
    check("t5_idle_floor", 32'(floor3), 2);

    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
